// File: rtl/snake_if.sv
// Bundle of the snake_engine game-control, renderer-query and status signals.
// master drives controls and queries; slave (the engine) answers.
interface snake_if #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 32,
    parameter int SCORE_W = 8
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               step;
    logic               start;
    logic               up;
    logic               down;
    logic               left;
    logic               right;
    logic [XW-1:0]      query_x;
    logic [YW-1:0]      query_y;
    logic               query_head;
    logic               query_body;
    logic               query_apple;
    logic [XW-1:0]      head_x;
    logic [YW-1:0]      head_y;
    logic [XW-1:0]      apple_x;
    logic [YW-1:0]      apple_y;
    logic [LW-1:0]      length;
    logic [SCORE_W-1:0] score;
    logic               running;
    logic               game_over;

    modport master (
        output step, start, up, down, left, right, query_x, query_y,
        input  query_head, query_body, query_apple, head_x, head_y,
               apple_x, apple_y, length, score, running, game_over
    );

    modport slave (
        input  step, start, up, down, left, right, query_x, query_y,
        output query_head, query_body, query_apple, head_x, head_y,
               apple_x, apple_y, length, score, running, game_over
    );
endinterface

// File: rtl/snake_engine.sv
// Grid snake game core: segment shift FIFO, LFSR apple placement, collision FSM.
// Define WALL_KILL_EN to end the game on leaving the grid instead of wrapping.
module snake_engine #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter int          MAX_LEN   = 32,
    parameter int          INIT_LEN  = 3,
    parameter int          SCORE_W   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic    clk,
    input logic    rst,
    snake_if.slave bus
);
    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int LW = $clog2(MAX_LEN + 1);

`ifdef WALL_KILL_EN
    localparam bit WALL_KILL = 1'b1;
`else
    localparam bit WALL_KILL = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PLACE, S_OVER} state_t;
    typedef enum logic [1:0] {D_RIGHT, D_LEFT, D_UP, D_DOWN} dir_t;

    state_t             state, state_next;
    dir_t               dir, last_dir, req_dir;
    logic               req_valid, dir_accept;
    logic [XW-1:0]      seg_x [MAX_LEN];
    logic [YW-1:0]      seg_y [MAX_LEN];
    logic [XW-1:0]      apple_x, cand_x, nh_x;
    logic [YW-1:0]      apple_y, cand_y, nh_y;
    logic [LW-1:0]      length, lim;
    logic [SCORE_W-1:0] score;
    logic [15:0]        lfsr;
    logic               off_grid, wall_hit, grow, collide, cand_ok;
    logic               do_init, do_move, do_place;

    function automatic logic [XW-1:0] init_x(int unsigned i);
        if (i < INIT_LEN) return XW'(GRID_W / 2 - int'(i));
        return '0;
    endfunction

    function automatic logic [YW-1:0] init_y(int unsigned i);
        if (i < INIT_LEN) return YW'(GRID_H / 2);
        return '0;
    endfunction

    function automatic dir_t opposite(dir_t d);
        case (d)
            D_RIGHT: return D_LEFT;
            D_LEFT:  return D_RIGHT;
            D_UP:    return D_DOWN;
            default: return D_UP;
        endcase
    endfunction

    // Highest-priority button only; a reversing request is dropped, not demoted.
    always_comb begin
        req_valid = 1'b1;
        req_dir   = D_RIGHT;
        if (bus.right)     req_dir = D_RIGHT;
        else if (bus.left) req_dir = D_LEFT;
        else if (bus.up)   req_dir = D_UP;
        else if (bus.down) req_dir = D_DOWN;
        else               req_valid = 1'b0;
        dir_accept = (state == S_RUN) && req_valid && (req_dir != opposite(last_dir));
    end

    always_comb begin
        nh_x     = seg_x[0];
        nh_y     = seg_y[0];
        off_grid = 1'b0;
        case (dir)
            D_RIGHT:
                if (seg_x[0] == XW'(GRID_W - 1)) begin
                    nh_x = '0; off_grid = 1'b1;
                end else nh_x = seg_x[0] + XW'(1);
            D_LEFT:
                if (seg_x[0] == '0) begin
                    nh_x = XW'(GRID_W - 1); off_grid = 1'b1;
                end else nh_x = seg_x[0] - XW'(1);
            D_UP:
                if (seg_y[0] == '0) begin
                    nh_y = YW'(GRID_H - 1); off_grid = 1'b1;
                end else nh_y = seg_y[0] - YW'(1);
            default:
                if (seg_y[0] == YW'(GRID_H - 1)) begin
                    nh_y = '0; off_grid = 1'b1;
                end else nh_y = seg_y[0] + YW'(1);
        endcase
        wall_hit = WALL_KILL && off_grid;
        grow     = (nh_x == apple_x) && (nh_y == apple_y);
    end

    // The tail cell is free to enter unless the snake grows this move.
    always_comb begin
        collide = 1'b0;
        lim     = grow ? length : length - LW'(1);
        for (int unsigned i = 0; i < MAX_LEN; i++)
            if (LW'(i) < lim && seg_x[i] == nh_x && seg_y[i] == nh_y)
                collide = 1'b1;
    end

    always_comb begin
        cand_x  = lfsr[XW-1:0];
        cand_y  = lfsr[XW+YW-1:XW];
        cand_ok = ({1'b0, cand_x} < (XW + 1)'(GRID_W)) &&
                  ({1'b0, cand_y} < (YW + 1)'(GRID_H));
        for (int unsigned i = 0; i < MAX_LEN; i++)
            if (LW'(i) < length && seg_x[i] == cand_x && seg_y[i] == cand_y)
                cand_ok = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_init    = 1'b0;
        do_move    = 1'b0;
        do_place   = 1'b0;
        case (state)
            S_IDLE, S_OVER:
                if (bus.start) begin
                    state_next = S_RUN;
                    do_init    = 1'b1;
                end
            S_RUN:
                if (bus.step) begin
                    if (collide || wall_hit) state_next = S_OVER;
                    else begin
                        do_move = 1'b1;
                        if (grow) state_next = S_PLACE;
                    end
                end
            S_PLACE:
                if (cand_ok) begin
                    do_place   = 1'b1;
                    state_next = S_RUN;
                end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr <= LFSR_SEED;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

        if (rst || do_init) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= init_y(i);
            end
            length   <= LW'(INIT_LEN);
            dir      <= D_RIGHT;
            last_dir <= D_RIGHT;
            apple_x  <= XW'(3 * GRID_W / 4);
            apple_y  <= YW'(GRID_H / 4);
            score    <= '0;
        end else begin
            if (dir_accept) dir <= req_dir;
            if (do_move) begin
                for (int unsigned i = 1; i < MAX_LEN; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                seg_x[0] <= nh_x;
                seg_y[0] <= nh_y;
                last_dir <= dir;
                if (grow) begin
                    if (score != '1) score <= score + SCORE_W'(1);
                    if (length != LW'(MAX_LEN)) length <= length + LW'(1);
                end
            end
            if (do_place) begin
                apple_x <= cand_x;
                apple_y <= cand_y;
            end
        end
    end

    always_comb begin
        bus.query_head  = (bus.query_x == seg_x[0]) && (bus.query_y == seg_y[0]);
        bus.query_apple = (bus.query_x == apple_x) && (bus.query_y == apple_y);
        bus.query_body  = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++)
            if (LW'(i) < length && bus.query_x == seg_x[i] && bus.query_y == seg_y[i])
                bus.query_body = 1'b1;
    end

    assign bus.head_x    = seg_x[0];
    assign bus.head_y    = seg_y[0];
    assign bus.apple_x   = apple_x;
    assign bus.apple_y   = apple_y;
    assign bus.length    = length;
    assign bus.score     = score;
    assign bus.running   = (state == S_RUN) || (state == S_PLACE);
    assign bus.game_over = (state == S_OVER);
endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: the driver queues expectations from a
// behavioural snake model and hand values; a negedge monitor compares them.
module tb_snake_engine;
    localparam int D_R = 0, D_L = 1, D_U = 2, D_D = 3;
    localparam int K_HX = 0, K_HY = 1, K_LEN = 2, K_SCORE = 3, K_RUN = 4, K_OVER = 5,
                   K_AX = 6, K_AY = 7, K_QHEAD = 8, K_QBODY = 9, K_QAPPLE = 10,
                   K_APPLE_OK = 11;
`ifdef WALL_KILL_EN
    localparam bit WALL = 1'b1;
`else
    localparam bit WALL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snake_if #(.GRID_W(40), .GRID_H(30), .MAX_LEN(32), .SCORE_W(8)) bus ();

    snake_engine #(
        .GRID_W(40), .GRID_H(30), .MAX_LEN(32), .INIT_LEN(3), .SCORE_W(8),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int    kind;
        int    exp;
        int    aux;
        string name;
    } chk_t;

    chk_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    int mx[32], my[32];
    int mlen, mscore, mdir, mlast, max, may;
    bit mover, midle;

    function automatic void push(int kind, int exp, int aux, string name);
        chk_t c;
        c.kind = kind; c.exp = exp; c.aux = aux; c.name = name;
        sbq.push_back(c);
    endfunction

    function automatic int actual_of(int kind, int aux);
        int ax, ay, ok;
        case (kind)
            K_HX:     return int'(bus.head_x);
            K_HY:     return int'(bus.head_y);
            K_LEN:    return int'(bus.length);
            K_SCORE:  return int'(bus.score);
            K_RUN:    return int'(bus.running);
            K_OVER:   return int'(bus.game_over);
            K_AX:     return int'(bus.apple_x);
            K_AY:     return int'(bus.apple_y);
            K_QHEAD:  return int'(bus.query_head);
            K_QBODY:  return int'(bus.query_body);
            K_QAPPLE: return int'(bus.query_apple);
            K_APPLE_OK: begin
                ax = int'(bus.apple_x);
                ay = int'(bus.apple_y);
                ok = (ax < 40 && ay < 30 && (ax * 64 + ay) != aux) ? 1 : 0;
                for (int i = 0; i < mlen; i++)
                    if (mx[i] == ax && my[i] == ay) ok = 0;
                return ok;
            end
            default: return -1;
        endcase
    endfunction

    initial begin
        chk_t c;
        int   act;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                c   = sbq.pop_front();
                act = actual_of(c.kind, c.aux);
                checks++;
                if (act != c.exp) begin
                    failures++;
                    $display("FAIL %s: got %0d expected %0d", c.name, act, c.exp);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int opp(int d);
        case (d)
            D_R:     return D_L;
            D_L:     return D_R;
            D_U:     return D_D;
            default: return D_U;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mx[i] = (i < 3) ? 20 - i : 0;
            my[i] = (i < 3) ? 15 : 0;
        end
        mlen = 3; mscore = 0; mdir = D_R; mlast = D_R;
        max = 30; may = 7; mover = 1'b0;
    endtask

    task automatic expect_state();
        push(K_HX, mx[0], 0, "head_x");
        push(K_HY, my[0], 0, "head_y");
        push(K_LEN, mlen, 0, "length");
        push(K_SCORE, mscore, 0, "score");
        push(K_RUN, (!mover && !midle) ? 1 : 0, 0, "running");
        push(K_OVER, mover ? 1 : 0, 0, "game_over");
    endtask

    task automatic query(int x, int y, int eh, int eb, int ea);
        bus.query_x = 6'(x);
        bus.query_y = 5'(y);
        push(K_QHEAD, eh, 0, "query_head");
        push(K_QBODY, eb, 0, "query_body");
        push(K_QAPPLE, ea, 0, "query_apple");
        tick();
    endtask

    task automatic press(int d);
        bus.right = (d == D_R); bus.left = (d == D_L);
        bus.up    = (d == D_U); bus.down = (d == D_D);
        tick();
        bus.right = 1'b0; bus.left = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
        if (d != opp(mlast)) mdir = d;
    endtask

    task automatic do_step(output bit g);
        int nx, ny, lim;
        bit off, hit;
        nx = mx[0]; ny = my[0]; off = 1'b0;
        case (mdir)
            D_R:     if (nx == 39) begin nx = 0;  off = 1'b1; end else nx++;
            D_L:     if (nx == 0)  begin nx = 39; off = 1'b1; end else nx--;
            D_U:     if (ny == 0)  begin ny = 29; off = 1'b1; end else ny--;
            default: if (ny == 29) begin ny = 0;  off = 1'b1; end else ny++;
        endcase
        g   = (nx == max) && (ny == may);
        lim = g ? mlen : mlen - 1;
        hit = WALL && off;
        for (int i = 0; i < lim; i++)
            if (mx[i] == nx && my[i] == ny) hit = 1'b1;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        if (hit) begin
            mover = 1'b1;
            g     = 1'b0;
        end else begin
            for (int i = 31; i > 0; i--) begin
                mx[i] = mx[i-1];
                my[i] = my[i-1];
            end
            mx[0] = nx; my[0] = ny; mlast = mdir;
            if (g) begin
                if (mscore < 255) mscore++;
                if (mlen < 32) mlen++;
            end
        end
        expect_state();
    endtask

    task automatic wait_apple();
        int old, n;
        old = max * 64 + may;
        n   = 0;
        while ((int'(bus.apple_x) * 64 + int'(bus.apple_y)) == old && n < 200) begin
            tick();
            n++;
        end
        push(K_APPLE_OK, 1, old, "apple_placed");
        max = int'(bus.apple_x);
        may = int'(bus.apple_y);
    endtask

    task automatic restart();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_reset();
        midle = 1'b0;
        expect_state();
    endtask

    initial begin
        bit g, forced;
        int eats, steps, d, base;
        int seq[3];

        bus.step = 1'b0; bus.start = 1'b0;
        bus.up = 1'b0; bus.down = 1'b0; bus.left = 1'b0; bus.right = 1'b0;
        bus.query_x = '0; bus.query_y = '0;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        midle = 1'b1;

        checks++;
        if (bus.head_x !== 6'd20) begin
            failures++;
            $display("FAIL direct_reset_head_x: got %0d expected 20", bus.head_x);
        end
        checks++;
        if (bus.head_y !== 5'd15) begin
            failures++;
            $display("FAIL direct_reset_head_y: got %0d expected 15", bus.head_y);
        end
        checks++;
        if (bus.length !== 6'd3) begin
            failures++;
            $display("FAIL direct_reset_length: got %0d expected 3", bus.length);
        end
        checks++;
        if (bus.apple_x !== 6'd30 || bus.apple_y !== 5'd7) begin
            failures++;
            $display("FAIL direct_reset_apple: got (%0d,%0d) expected (30,7)",
                     bus.apple_x, bus.apple_y);
        end
        checks++;
        if (bus.running !== 1'b0) begin
            failures++;
            $display("FAIL direct_reset_running: got %0d expected 0", bus.running);
        end

        expect_state();
        push(K_HX, 20, 0, "reset_head_x");
        push(K_AX, 30, 0, "reset_apple_x");
        push(K_AY, 7, 0, "reset_apple_y");
        tick();
        query(20, 15, 1, 0, 0);
        query(19, 15, 0, 1, 0);
        query(18, 15, 0, 1, 0);
        query(17, 15, 0, 0, 0);
        query(0, 0, 0, 0, 0);
        query(30, 7, 0, 0, 1);

        for (int i = 0; i < 20; i++) begin
            bus.step = (i % 2 == 0);
            tick();
        end
        bus.step = 1'b0;
        expect_state();
        tick();

        restart();
        for (int k = 1; k <= 20; k++) begin
            do_step(g);
            if (k < 20) push(K_HX, 20 + k, 0, "right_run_x");
        end
        push(K_HX, WALL ? 39 : 0, 0, "edge_x");
        push(K_OVER, WALL ? 1 : 0, 0, "edge_over");
        push(K_LEN, 3, 0, "edge_len");
        tick();
        if (mover) restart();
        base = mx[0];

        press(D_L);
        do_step(g);
        push(K_HX, base + 1, 0, "left_rejected_x");
        press(D_U);
        press(D_L);
        do_step(g);
        push(K_HX, base + 1, 0, "up_then_left_x");
        push(K_HY, 14, 0, "up_then_left_y");

        eats = 0; steps = 0; forced = 1'b0;
        while (eats < 50 && !mover && steps < 5000) begin
            d = forced ? D_R : ((my[0] != may) ? D_U : D_R);
            if (d != mdir) press(d);
            do_step(g);
            forced = 1'b0;
            if (g) begin
                eats++;
                forced = 1'b1;
                wait_apple();
            end
            steps++;
        end
`ifndef WALL_KILL_EN
        push(K_SCORE, 50, 0, "score_after_50");
        push(K_LEN, 32, 0, "length_saturated");
`endif
        tick();

        if (mover) restart();
        if (mlast == D_U) begin
            seq[0] = D_R; seq[1] = D_D; seq[2] = D_L;
        end else begin
            seq[0] = D_D; seq[1] = D_L; seq[2] = D_U;
        end
        for (int i = 0; i < 3; i++) begin
            if (!mover) begin
                press(seq[i]);
                do_step(g);
                if (g) wait_apple();
            end
        end
        push(K_OVER, 1, 0, "self_collision");
        tick();

        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        expect_state();
        tick();

        bus.start = 1'b1;
        bus.step  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.step  = 1'b0;
        model_reset();
        midle = 1'b0;
        expect_state();
        push(K_HX, 20, 0, "restart_head_x");
        push(K_LEN, 3, 0, "restart_len");
        push(K_SCORE, 0, 0, "restart_score");
        push(K_AX, 30, 0, "restart_apple_x");
        push(K_AY, 7, 0, "restart_apple_y");
        tick();
        do_step(g);
        push(K_HX, 21, 0, "after_restart_x");
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        midle = 1'b1;

        checks++;
        if (bus.head_x !== 6'd20) begin
            failures++;
            $display("FAIL direct_rerst_head_x: got %0d expected 20", bus.head_x);
        end
        checks++;
        if (bus.length !== 6'd3) begin
            failures++;
            $display("FAIL direct_rerst_length: got %0d expected 3", bus.length);
        end

        expect_state();
        tick();

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
